// File: rtl/matrix_pkg.sv
// Shared state encoding and sizing helpers for the matrix multiply engine.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT  = 3;
  localparam int DW_DEFAULT = 8;

  // Full product width plus enough guard bits to sum N products without overflow.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate slice: sum = acc + a*b, where the product is sign-extended to AW.
// The engine reads sum directly on the final term of a dot product and clears acc at the same time.
module mac_unit #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] sum
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] acc_q, acc_d;

  assign prod     = PW'(a) * PW'(b);
  assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
  assign sum      = acc_q + prod_ext;

  // clr has priority over en, so the last term of a dot product restarts the sum at zero.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mac_engine.sv
// Sequential signed N x N matrix multiplier C = A * B using one shared MAC per cycle.
// A/B are loaded through a write port while idle; C is read combinationally at any time.
module matrix_mac_engine
  import matrix_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int AW = acc_width(N, DW)
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [DW-1:0]        wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic [$clog2(N)-1:0] rd_row,
  input  logic [$clog2(N)-1:0] rd_col,
  output logic [AW-1:0]        rd_data
);

  localparam int            IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [DW-1:0] a_q [N][N];
  logic signed [DW-1:0] a_d [N][N];
  logic signed [DW-1:0] b_q [N][N];
  logic signed [DW-1:0] b_d [N][N];
  logic signed [AW-1:0] c_q [N][N];
  logic signed [AW-1:0] c_d [N][N];

  logic mac_en, mac_clr;
  logic signed [AW-1:0] mac_sum;
  logic wr_ok, rd_ok, last_k, last_j, last_i;

  // Index checks fold away when N is a power of two.
  assign wr_ok  = (int'(wr_row) < N) && (int'(wr_col) < N);
  assign rd_ok  = (int'(rd_row) < N) && (int'(rd_col) < N);
  assign last_k = (k_q == LAST);
  assign last_j = (j_q == LAST);
  assign last_i = (i_q == LAST);

  mac_unit #(.DW(DW), .AW(AW)) u_mac (
    .Clk    (Clk),
    .nReset (nReset),
    .en     (mac_en),
    .clr    (mac_clr),
    .a      (a_q[i_q][k_q]),
    .b      (b_q[k_q][j_q]),
    .sum    (mac_sum)
  );

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_k && last_j && last_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en && wr_ok) begin
          if (wr_sel) b_d[wr_row][wr_col] = wr_data;
          else        a_d[wr_row][wr_col] = wr_data;
        end
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
        end
      end
      CALC: begin
        mac_en = 1'b1;
        if (last_k) begin
          // The final term goes straight into C; the accumulator restarts for the next element.
          c_d[i_q][j_q] = mac_sum;
          mac_clr       = 1'b1;
          k_d           = '0;
          if (last_j) begin
            j_d = '0;
            i_d = last_i ? '0 : i_q + IW'(1);
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          c_q[r][c] <= '0;
        end
      end
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  assign rd_data = rd_ok ? c_q[rd_row][rd_col] : '0;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Scoreboard bench for matrix_mac_engine: stimulus queues expected C matrices, a monitor checks them on done.
module tb_matrix_mac_engine;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 18;

  logic          Clk     = 1'b0;
  logic          nReset  = 1'b0;
  logic          wr_en   = 1'b0;
  logic          wr_sel  = 1'b0;
  logic [1:0]    wr_row  = '0;
  logic [1:0]    wr_col  = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start   = 1'b0;
  logic          busy;
  logic          done;
  logic [1:0]    rd_row  = '0;
  logic [1:0]    rd_col  = '0;
  logic [AW-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  string tagq [$];
  int    expq [$];
  logic  snap_req = 1'b0;

  int ma [9];
  int mb [9];
  int ev [9];

  always #10 Clk = ~Clk;

  matrix_mac_engine #(.N(N), .DW(DW), .AW(AW)) dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int r, input int c, input int v);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = 2'(r);
    wr_col  = 2'(c);
    wr_data = 8'(v);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        wr(1'b0, r, c, ma[r*3+c]);
        wr(1'b1, r, c, mb[r*3+c]);
      end
    end
  endtask

  task automatic push_exp(input string tag);
    tagq.push_back(tag);
    for (int e = 0; e < 9; e++) expq.push_back(ev[e]);
  endtask

  task automatic snap(input string tag);
    push_exp(tag);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
  endtask

  // Issue start and watch busy/done; optionally inject start+write mid-CALC or a reset.
  task automatic run(input string tag, input int inj_at, input int rst_at, input bit exp_done);
    int cyc;
    int nbusy;
    int done_cyc;
    int ndone;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; nbusy = 0; done_cyc = 0; ndone = 0;
    while (cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (inj_at > 0 && cyc == inj_at) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
        wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd99;
      end else if (inj_at > 0 && cyc == inj_at + 1) begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (rst_at > 0 && cyc == rst_at) nReset = 1'b0;
      if (rst_at > 0 && cyc == rst_at + 1) begin
        chk({tag, " busy_after_reset"}, int'(busy), 0);
        chk({tag, " done_after_reset"}, int'(done), 0);
        nReset = 1'b1;
      end
    end
    if (exp_done) begin
      chk({tag, " done_cycle"}, done_cyc, 28);
      chk({tag, " busy_cycles"}, nbusy, 27);
      chk({tag, " done_count"}, ndone, 1);
    end else begin
      chk({tag, " done_count"}, ndone, 0);
    end
    $display("run %s: done_cycle=%0d busy_cycles=%0d done_count=%0d", tag, done_cyc, nbusy, ndone);
    tick();
  endtask

  // Monitor: on done (or a snapshot request) read all of C and compare to the oldest expectation.
  initial begin
    string tag;
    int    req;
    forever begin
      @(negedge Clk);
      if (done || snap_req) begin
        if (tagq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=%0b with no result queued, required no done", done);
        end else begin
          tag = tagq.pop_front();
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
              rd_row = 2'(r);
              rd_col = 2'(c);
              #1;
              req = expq.pop_front();
              chk($sformatf("%s C[%0d][%0d]", tag, r, c), int'($signed(rd_data)), req);
            end
          end
          $display("check %s: C matrix compared", tag);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    tick();
    tick();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    ev = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    snap("reset");
    nReset = 1'b1;
    tick();

    // 2: basic product
    ma = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load();
    ev = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    push_exp("t2");
    run("t2", 0, 0, 1'b1);

    // 3: signed extremes
    for (int e = 0; e < 9; e++) begin ma[e] = -128; mb[e] = -128; ev[e] = 49152; end
    load();
    push_exp("t3a");
    run("t3a", 0, 0, 1'b1);
    for (int e = 0; e < 9; e++) begin ma[e] = 127; mb[e] = -128; ev[e] = -48768; end
    load();
    push_exp("t3b");
    run("t3b", 0, 0, 1'b1);

    // 4: identity times B
    ma = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    mb = '{-1, 0, 5, 2, -3, 7, 9, 4, -6};
    load();
    ev = '{-1, 0, 5, 2, -3, 7, 9, 4, -6};
    push_exp("t4");
    run("t4", 0, 0, 1'b1);

    // 5: start and write during CALC are ignored
    ma = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load();
    ev = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    push_exp("t5");
    run("t5", 5, 0, 1'b1);

    // 6: reset mid-CALC discards everything, then a clean rerun
    run("t6_abort", 0, 10, 1'b0);
    ev = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    snap("t6_cleared");
    load();
    ev = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    push_exp("t6_rerun");
    run("t6_rerun", 0, 0, 1'b1);

    chk("pending_results", tagq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
